axi_wr_beat_gen: RTL

AXI4 slave write front-end that sits directly downstream of the AXI master/interconnect and upstream of the testbench's word-addressed memory. It accepts one write burst at a time on AW/W, expands it into per-beat memory write strobes with FIXED/INCR/WRAP address generation, and returns the B response. The ID/ADDR/DATA widths come from the shared testbench parameters (6/32/32).

---
 rtl/axi_wr_pkg.sv | 28 ++
 rtl/axi_wr_beat_gen_if.sv | 56 +++++
 rtl/axi_addr_next.sv | 33 +++
 rtl/axi_wr_beat_gen.sv | 124 ++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared AXI write-side types: burst encodings, response codes and FSM states.
// Used by axi_wr_beat_gen and by the address calculator shared with the read side.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } state_e;

  // Wrapping bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_beat_gen_if.sv
// AXI4 write channels plus the per-beat memory port of axi_wr_beat_gen.
// Every valid/ready pair transfers on a rising edge where both are high; a source holds valid and payload until then.
interface axi_wr_beat_gen_if #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );

endinterface

// File: rtl/axi_addr_next.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// Shared between the write and read front-ends.
module axi_addr_next
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  burst_e            burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] total;
  logic [ADDR_W-1:0] wrap_base;

  assign incr      = ADDR_W'(1) << size;
  assign total     = (ADDR_W'(len) + ADDR_W'(1)) << size;
  assign wrap_base = addr & ~(total - ADDR_W'(1));

  always_comb begin
    next_addr = addr;
    case (burst)
      INCR:    next_addr = (addr & ~(incr - ADDR_W'(1))) + incr;
      // Legal wrap lengths make total a power of two, so the modulo is a mask.
      WRAP:    next_addr = wrap_base + ((addr + incr - wrap_base) & (total - ADDR_W'(1)));
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_beat_gen.sv
// AXI4 write slave front-end: one burst at a time, expanded into per-beat memory writes, then B.
// Optional wlast checking is enabled with the macro AXI_WR_BEAT_GEN_WLAST_CHECK_EN.
module axi_wr_beat_gen
  import axi_wr_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 6,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_wr_beat_gen_if.slave     bus,
  output state_e               dbg_state
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

  state_e                      state_q, state_d;
  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_next;
  logic [7:0]                  len_q;
  logic [2:0]                  size_q;
  burst_e                      burst_q;
  logic [7:0]                  cnt_q;
  logic                        err_q;

  logic aw_hs, w_hs, aw_err, wlast_bad;
  logic awready, wready, bvalid, mem_we;

  assign aw_err = (bus.awsize > MAX_SIZE) ||
                  (bus.awburst == RSVD) ||
                  ((bus.awburst == WRAP) && !wrap_len_ok(bus.awlen));

`ifdef AXI_WR_BEAT_GEN_WLAST_CHECK_EN
  assign wlast_bad = (bus.wlast != (cnt_q == len_q));
`else
  assign wlast_bad = 1'b0;
`endif

  axi_addr_next #(
    .ADDR_W (C_AXI_ADDR_WIDTH)
  ) u_addr_next (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (addr_next)
  );

  always_comb begin
    state_d = state_q;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        awready = 1'b1;
        if (bus.awvalid) begin
          aw_hs   = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        wready = bus.mem_ready;
        if (bus.wvalid && bus.mem_ready) begin
          w_hs = 1'b1;
          // A bad wlast suppresses its own beat as well as the rest.
          mem_we = !err_q && !wlast_bad;
          if (cnt_q == len_q) state_d = RESP;
        end
      end
      RESP: begin
        bvalid = 1'b1;
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= FIXED;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q    <= bus.awid;
        addr_q  <= bus.awaddr;
        len_q   <= bus.awlen;
        size_q  <= bus.awsize;
        burst_q <= burst_e'(bus.awburst);
        cnt_q   <= '0;
        err_q   <= aw_err;
      end
      if (w_hs) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= addr_next;
        if (wlast_bad) err_q <= 1'b1;
      end
    end
  end

  assign bus.awready   = awready;
  assign bus.wready    = wready;
  assign bus.bvalid    = bvalid;
  assign bus.bid       = id_q;
  assign bus.bresp     = ((state_q == RESP) && err_q) ? SLVERR : OKAY;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.wdata;
  assign bus.mem_wstrb = bus.wstrb;
  assign dbg_state     = state_q;

endmodule
